uart_tx_mmio: RTL and testbench

UART_TX_MMIO -- requirements
Module: uart_tx_mmio

---
 rtl/uart_pkg.sv | 12 +
 rtl/sync_fifo_tx.sv | 48 ++++
 rtl/uart_tx_mmio.sv | 116 +++++++++++
 tb/tb_uart_tx_mmio.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, STATUS bit indices and TX FSM states shared by the UART TX slice
package uart_pkg;
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_CNT   = 4;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;
endpackage

// File: rtl/sync_fifo_tx.sv
// sync_fifo_tx: byte FIFO with wrapping pointers; a push while full or a pop while empty is ignored
module sync_fifo_tx #(
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction
  assign full   = r_cnt == CW'(DEPTH);
  assign empty  = r_cnt == '0;
  assign count  = r_cnt;
  assign dout   = r_mem[r_rd];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  // storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end
  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= nxt(r_wr);
      if (w_pop) r_rd <= nxt(r_rd);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter; define UART_TX_FIFO_EN for a FIFO_DEPTH-entry FIFO, otherwise a single holding register
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cs_n,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [3:0]  byte_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        uart_txd,
  output logic        irq
);
`ifdef UART_TX_FIFO_EN
  localparam int DEPTH = FIFO_DEPTH;
`else
  localparam int DEPTH = 1;
`endif
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [15:0] DIV_M1 = 16'(CLOCK_FREQ / BAUD_RATE - 1);
  tx_state_e     r_state;
  logic [15:0]   r_baud;
  logic [2:0]    r_idx;
  logic [7:0]    r_sh;
  logic          r_txd;
  logic          r_ovf;
  logic          r_ie;
  logic          w_wr;
  logic [1:0]    w_sel;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [7:0]    w_dout;
  logic [CW-1:0] w_count;
  logic [31:0]   w_status;
  logic          w_unused;
  assign w_unused = ^{addr[1:0], byte_en[3:1], wdata[31:8]};
  assign w_sel    = addr[3:2];
  assign w_wr     = ~cs_n & we & byte_en[0];
  assign w_pop    = (r_state == S_IDLE) & ~w_empty;
  assign uart_txd = r_txd;
  assign irq      = r_ie & w_empty & (r_state == S_IDLE);
  sync_fifo_tx #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (w_wr & (w_sel == REG_TXDATA)),
    .pop   (w_pop),
    .din   (wdata[7:0]),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );
  // STATUS word assembled from live state
  always_comb begin
    w_status           = '0;
    w_status[ST_BUSY]  = r_state != S_IDLE;
    w_status[ST_FULL]  = w_full;
    w_status[ST_EMPTY] = w_empty;
    w_status[ST_OVF]   = r_ovf;
    w_status[ST_CNT+:4] = 4'(w_count);
  end
  assign rdata = cs_n ? '0 : (w_sel == REG_STATUS) ? w_status : (w_sel == REG_CTRL) ? {31'b0, r_ie} : '0;
  // sticky overflow on a dropped TXDATA write, interrupt enable in CTRL
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_ovf <= 1'b0;
      r_ie  <= 1'b0;
    end else begin
      if (w_wr & (w_sel == REG_TXDATA) & w_full) r_ovf <= 1'b1;
      else if (w_wr & (w_sel == REG_STATUS) & wdata[3]) r_ovf <= 1'b0;
      if (w_wr & (w_sel == REG_CTRL)) r_ie <= wdata[0];
    end
  end
  // frame shifter: start bit, 8 data bits LSB first, stop bit, each DIV cycles
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_idx   <= '0;
      r_sh    <= '0;
      r_txd   <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: if (!w_empty) begin
          r_state <= S_START;
          r_sh    <= w_dout;
          r_txd   <= 1'b0;
          r_baud  <= DIV_M1;
        end
        S_START: if (r_baud == '0) begin
          r_state <= S_DATA;
          r_txd   <= r_sh[0];
          r_idx   <= '0;
          r_baud  <= DIV_M1;
        end else r_baud <= r_baud - 16'd1;
        S_DATA: if (r_baud == '0) begin
          r_baud <= DIV_M1;
          r_sh   <= r_sh >> 1;
          r_idx  <= r_idx + 3'd1;
          r_txd  <= (r_idx == 3'd7) ? 1'b1 : r_sh[1];
          if (r_idx == 3'd7) r_state <= S_STOP;
        end else r_baud <= r_baud - 16'd1;
        S_STOP: if (r_baud == '0) r_state <= S_IDLE;
        else r_baud <= r_baud - 16'd1;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: queue-based line/register model checked every cycle, plus literal frame and STATUS expectations
module tb_uart_tx_mmio;
  localparam int CF = 1_000_000;
  localparam int BR = 62_000;
  localparam int FD = 8;
  localparam int DIV = CF / BR;
  localparam int FL = 10 * DIV;
`ifdef UART_TX_FIFO_EN
  localparam int MD = FD;
`else
  localparam int MD = 1;
`endif
  logic clk = 0, n_rst = 1, cs_n = 0, we = 0;
  logic [3:0] addr = 4'h4, byte_en = 4'h0;
  logic [31:0] wdata = 0, rdata;
  logic uart_txd, irq;
  int tests = 0, fails = 0;
  logic [7:0] q[$];
  logic [7:0] m_cur = 0;
  int pos = 0, sz = 0;
  bit ovf = 0, ie = 0, wr_q = 0;

  always #5 clk = ~clk;

  uart_tx_mmio #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .n_rst(n_rst), .cs_n(cs_n), .we(we), .addr(addr), .byte_en(byte_en),
    .wdata(wdata), .rdata(rdata), .uart_txd(uart_txd), .irq(irq));

  // model: pos counts cycles into the current frame (0 = idle), frame length 10*DIV
  always begin
    @(posedge clk or negedge n_rst);
    if (!n_rst) begin
      q.delete(); pos = 0; ovf = 0; ie = 0; m_cur = 0;
    end else begin
      sz = q.size();
      wr_q = !cs_n && we && byte_en[0];
      if (pos == 0 && sz > 0) begin m_cur = q.pop_front(); pos = 1; end
      else if (pos > 0) pos = (pos == FL) ? 0 : pos + 1;
      if (wr_q && addr[3:2] == 2'd0) begin
        if (sz < MD) q.push_back(wdata[7:0]); else ovf = 1;
      end
      if (wr_q && addr[3:2] == 2'd1 && wdata[3]) ovf = 0;
      if (wr_q && addr[3:2] == 2'd2) ie = wdata[0];
    end
  end

  function automatic logic m_txd();
    int k;
    if (pos == 0) return 1'b1;
    k = (pos - 1) / DIV;
    return (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : m_cur[k-1];
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a);
    logic [31:0] s;
    s = 0;
    s[0] = pos != 0;
    s[1] = q.size() == MD;
    s[2] = q.size() == 0;
    s[3] = ovf;
    s[7:4] = 4'(q.size());
    return (a[3:2] == 2'd1) ? s : (a[3:2] == 2'd2) ? {31'b0, ie} : 32'h0;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic timeout(input string n);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired at %0t", n, $time);
  endtask

  always @(negedge clk) begin
    chk("txd", 32'(uart_txd), 32'(m_txd()));
    chk("irq", 32'(irq), 32'(ie && q.size() == 0 && pos == 0));
    chk("rdata", rdata, cs_n ? 32'h0 : m_read(addr));
  end

  task automatic wrn(input logic [3:0] a, input logic [31:0] d, input int n, input logic [3:0] be);
    @(posedge clk); #1;
    we = 1; addr = a; byte_en = be;
    for (int i = 0; i < n; i++) begin
      wdata = d + 32'(i);
      @(posedge clk); #1;
    end
    we = 0; addr = 4'h4; byte_en = 0; wdata = 0;
  endtask

  task automatic rd_chk(input string n, input logic [3:0] a, input logic [31:0] m, input logic [31:0] e);
    @(posedge clk); #1;
    addr = a; #1;
    chk(n, rdata & m, e);
    addr = 4'h4;
  endtask

  task automatic wait_idle(input string n);
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if (pos == 0 && q.size() == 0) return;
    end
    timeout(n);
  endtask

  task automatic frame_chk(input string n, input logic [8:0] e);
    int len;
    logic [8:0] v;
    len = 0;
    for (int i = 0; i < 400 && uart_txd; i++) @(negedge clk);
    if (uart_txd) begin timeout(n); return; end
    len = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (uart_txd) break;
      len++;
    end
    chk({n, "_start_len"}, 32'(len), 32'd16);
    repeat (DIV / 2) @(negedge clk);
    v[0] = uart_txd;
    for (int i = 1; i < 9; i++) begin
      repeat (DIV) @(negedge clk);
      v[i] = uart_txd;
    end
    chk({n, "_bits"}, 32'(v), 32'(e));
  endtask

  initial begin
    int n;
    #1 n_rst = 0;
    #2;
    chk("rst_txd", 32'(uart_txd), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_status", rdata, 32'h04);
    repeat (2) @(posedge clk);
    #1 n_rst = 1;
    rd_chk("ctrl_rst", 4'h8, 32'hFFFF_FFFF, 32'h0);
    rd_chk("addr_c", 4'hC, 32'hFFFF_FFFF, 32'h0);
    @(posedge clk); #1;
    cs_n = 1; #1;
    chk("cs_n_high", rdata, 32'h0);
    cs_n = 0;
    wrn(4'h0, 32'h11, 1, 4'hE);
    rd_chk("be0_low_ignored", 4'h4, 32'hFFFF_FFFF, 32'h04);
    wrn(4'h8, 32'h1, 1, 4'hE);
    rd_chk("ctrl_be_ignored", 4'h8, 32'hFFFF_FFFF, 32'h0);
    wrn(4'h0, 32'hFFFF_FF55, 1, 4'hF);
    frame_chk("f55", 9'h155);
    wait_idle("idle_f55");
    wrn(4'h0, 32'h30, 2, 4'h1);
`ifdef UART_TX_FIFO_EN
    rd_chk("b2b_status", 4'h4, 32'hFFFF_FFFF, 32'h11);
`else
    rd_chk("b2b_status", 4'h4, 32'hFFFF_FFFF, 32'h0D);
`endif
    wrn(4'h4, 32'h8, 1, 4'h1);
    wait_idle("idle_b2b");
    wrn(4'h0, 32'h55, 1, 4'h1);
    repeat (3) @(posedge clk);
    wrn(4'h0, 32'h40, MD + 1, 4'h1);
`ifdef UART_TX_FIFO_EN
    rd_chk("full_status", 4'h4, 32'hFFFF_FFFF, 32'h8B);
    wrn(4'h4, 32'h8, 1, 4'h1);
    rd_chk("ovf_clear", 4'h4, 32'hFFFF_FFFF, 32'h83);
`else
    rd_chk("full_status", 4'h4, 32'hFFFF_FFFF, 32'h1B);
    wrn(4'h4, 32'h8, 1, 4'h1);
    rd_chk("ovf_clear", 4'h4, 32'hFFFF_FFFF, 32'h13);
`endif
    n = 0;
    while (!(pos == 0 && q.size() > 0) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) timeout("pop_cycle");
    we = 1; addr = 4'h0; byte_en = 4'h1; wdata = 32'h77;
    @(posedge clk); #1;
    we = 0; addr = 4'h4; byte_en = 0; wdata = 0;
    rd_chk("push_on_pop_ovf", 4'h4, 32'h8, 32'h8);
    wrn(4'h4, 32'h8, 1, 4'h1);
    wait_idle("idle_full");
    wrn(4'h8, 32'h1, 1, 4'h1);
    rd_chk("ctrl_set", 4'h8, 32'hFFFF_FFFF, 32'h1);
    chk("irq_idle", 32'(irq), 32'd1);
    wrn(4'h0, 32'h3C, 1, 4'h1);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (irq) break;
      n++;
    end
    chk("irq_low_cycles", 32'(n), 32'd161);
    wrn(4'h8, 32'h0, 1, 4'h1);
    wait_idle("idle_irq");
    wrn(4'h0, 32'h0F, 1, 4'h1);
    n = 0;
    while (pos != 4 * DIV + 4 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) timeout("reach_bit3");
    #1 n_rst = 0;
    #1;
    chk("midrst_txd", 32'(uart_txd), 32'd1);
    chk("midrst_status", rdata, 32'h04);
    chk("midrst_irq", 32'(irq), 32'd0);
    @(posedge clk); #1 n_rst = 1;
    wrn(4'h0, 32'hA5, 1, 4'h1);
    frame_chk("fA5", 9'h1A5);
    wait_idle("idle_fA5");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
